// File: rtl/switch_multi_queue_frame_fifo.sv
// switch_multi_queue_frame_fifo: shared-RAM multi-queue frame FIFO with drop-on-full writes and round-robin frame reads
module switch_multi_queue_frame_fifo #(
   parameter int NUM_QUEUES     = 4,
   parameter int DEPTH          = 64,
   parameter int DATA_WIDTH     = 12,
   parameter bit DROP_BAD_FRAME = 1,
   localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic [QW-1:0]                  wr_queue,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic                           wr_eof,
   input  logic                           wr_drop,
   output logic [DATA_WIDTH-1:0]          rd_data,
   output logic                           rd_eof,
   output logic [QW-1:0]                  rd_queue,
   output logic                           rd_valid,
   input  logic                           rd_ready,
   output logic [NUM_QUEUES*(AW+1)-1:0]   status_depth,
   output logic [NUM_QUEUES-1:0]          status_nonempty,
   output logic                           status_overflow,
   output logic                           status_bad_frame,
   output logic                           status_good_frame
);
   if ((1 << AW) != DEPTH) begin : g_depth_check
      $error("DEPTH must be a power of 2");
   end
   typedef enum logic {IDLE, STREAM} state_t;
   state_t state, state_nxt;
   logic [DATA_WIDTH:0] ram [NUM_QUEUES*DEPTH];
   logic [AW:0] wr_ptr [NUM_QUEUES];
   logic [AW:0] wr_commit [NUM_QUEUES];
   logic [AW:0] rd_ptr [NUM_QUEUES];
   logic [AW:0] frame_cnt [NUM_QUEUES];
   logic in_frame, dropping;
   logic [QW-1:0] cur_q, q_sel, grant, last_grant, rr_sel;
   logic q_full, drop_beat, bad, commit_ev, rr_found, rd_load, rd_done;
   logic [DATA_WIDTH:0] rd_word;
   int k;
   assign wr_ready  = 1'b1;
   assign q_sel     = in_frame ? cur_q : wr_queue;
   assign q_full    = wr_ptr[q_sel] == (rd_ptr[q_sel] ^ {1'b1, {AW{1'b0}}});
   assign drop_beat = dropping || q_full;
   assign bad       = DROP_BAD_FRAME && wr_drop;
   assign commit_ev = wr_valid && !drop_beat && wr_eof && !bad;
   assign rd_word   = ram[{grant, rd_ptr[grant][AW-1:0]}];
   assign rd_load   = (state == STREAM) && (!rd_valid || rd_ready);
   assign rd_done   = rd_load && rd_word[DATA_WIDTH];
   // first queue holding a whole frame, searching onward from the last one served
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = last_grant;
      k        = 0;
      for (int i = 1; i <= NUM_QUEUES; i++) begin
         k = (int'(last_grant) + i) % NUM_QUEUES;
         if (!rr_found && frame_cnt[k] != '0) begin
            rr_found = 1'b1;
            rr_sel   = QW'(k);
         end
      end
   end
   always_comb begin
      state_nxt = (state == IDLE) ? (rr_found ? STREAM : IDLE) : (rd_done ? IDLE : STREAM);
   end
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_nxt;
   end
   always_ff @(posedge clk) begin
      if (wr_valid && !drop_beat)
         ram[{q_sel, wr_ptr[q_sel][AW-1:0]}] <= {wr_eof, wr_data};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         in_frame          <= 1'b0;
         dropping          <= 1'b0;
         cur_q             <= '0;
         grant             <= '0;
         last_grant        <= QW'(NUM_QUEUES - 1);
         rd_data           <= '0;
         rd_eof            <= 1'b0;
         rd_queue          <= '0;
         rd_valid          <= 1'b0;
         status_depth      <= '0;
         status_nonempty   <= '0;
         status_overflow   <= 1'b0;
         status_bad_frame  <= 1'b0;
         status_good_frame <= 1'b0;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            wr_ptr[q]    <= '0;
            wr_commit[q] <= '0;
            rd_ptr[q]    <= '0;
            frame_cnt[q] <= '0;
         end
      end else begin
         status_overflow   <= 1'b0;
         status_bad_frame  <= 1'b0;
         status_good_frame <= 1'b0;
         if (wr_valid) begin
            in_frame <= !wr_eof;
            if (!in_frame)
               cur_q <= wr_queue;
            if (drop_beat) begin
               dropping <= !wr_eof;
               if (wr_eof) begin
                  wr_ptr[q_sel]   <= wr_commit[q_sel];
                  status_overflow <= 1'b1;
               end
            end else if (wr_eof && bad) begin
               wr_ptr[q_sel]    <= wr_commit[q_sel];
               status_bad_frame <= 1'b1;
            end else begin
               wr_ptr[q_sel] <= wr_ptr[q_sel] + 1'b1;
               if (wr_eof) begin
                  wr_commit[q_sel]  <= wr_ptr[q_sel] + 1'b1;
                  status_good_frame <= 1'b1;
               end
            end
         end
         // a commit and a frame read-out on the same queue cancel in frame_cnt
         for (int q = 0; q < NUM_QUEUES; q++) begin
            frame_cnt[q] <= frame_cnt[q]
                          + {{AW{1'b0}}, commit_ev && (q_sel == QW'(q))}
                          - {{AW{1'b0}}, rd_done && (grant == QW'(q))};
            status_depth[q*(AW+1) +: AW+1] <= wr_commit[q] - rd_ptr[q];
            status_nonempty[q]             <= frame_cnt[q] != '0;
         end
         if (state == IDLE && rd_ready)
            rd_valid <= 1'b0;
         if (state == IDLE && rr_found)
            grant <= rr_sel;
         if (rd_load) begin
            rd_data       <= rd_word[DATA_WIDTH-1:0];
            rd_eof        <= rd_word[DATA_WIDTH];
            rd_valid      <= 1'b1;
            rd_queue      <= grant;
            rd_ptr[grant] <= rd_ptr[grant] + 1'b1;
            if (rd_word[DATA_WIDTH])
               last_grant <= grant;
         end
      end
   end
endmodule

// File: tb/tb_switch_multi_queue_frame_fifo.sv
// tb_switch_multi_queue_frame_fifo: scoreboard bench; expected beats queued at write time, popped by a read monitor
module tb_switch_multi_queue_frame_fifo;
   localparam int NQ = 4, DEPTH = 64, DW = 12, QW = 2, AW = 6;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [DW-1:0] wr_data = '0;
   logic [QW-1:0] wr_queue = '0;
   logic wr_valid = 1'b0, wr_eof = 1'b0, wr_drop = 1'b0, rd_ready = 1'b0, nb_ready = 1'b1;
   logic wr_ready, rd_eof, rd_valid, status_overflow, status_bad_frame, status_good_frame;
   logic [DW-1:0] rd_data;
   logic [QW-1:0] rd_queue;
   logic [NQ*(AW+1)-1:0] status_depth;
   logic [NQ-1:0] status_nonempty;
   logic nb_wr_ready, nb_rd_eof, nb_rd_valid, nb_ovf, nb_bad, nb_good;
   logic [DW-1:0] nb_rd_data;
   logic [QW-1:0] nb_rd_queue;
   logic [NQ*(AW+1)-1:0] nb_depth;
   logic [NQ-1:0] nb_nonempty;

   switch_multi_queue_frame_fifo #(.NUM_QUEUES(NQ), .DEPTH(DEPTH), .DATA_WIDTH(DW), .DROP_BAD_FRAME(1)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_queue(wr_queue), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_eof(wr_eof), .wr_drop(wr_drop), .rd_data(rd_data), .rd_eof(rd_eof), .rd_queue(rd_queue),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .status_depth(status_depth), .status_nonempty(status_nonempty),
      .status_overflow(status_overflow), .status_bad_frame(status_bad_frame), .status_good_frame(status_good_frame));

   switch_multi_queue_frame_fifo #(.NUM_QUEUES(NQ), .DEPTH(DEPTH), .DATA_WIDTH(DW), .DROP_BAD_FRAME(0)) dut_nb (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_queue(wr_queue), .wr_valid(wr_valid), .wr_ready(nb_wr_ready),
      .wr_eof(wr_eof), .wr_drop(wr_drop), .rd_data(nb_rd_data), .rd_eof(nb_rd_eof), .rd_queue(nb_rd_queue),
      .rd_valid(nb_rd_valid), .rd_ready(nb_ready), .status_depth(nb_depth), .status_nonempty(nb_nonempty),
      .status_overflow(nb_ovf), .status_bad_frame(nb_bad), .status_good_frame(nb_good));

   int n_chk = 0, n_fail = 0;
   int good_cnt = 0, bad_cnt = 0, ovf_cnt = 0, nb_good_cnt = 0, nb_bad_cnt = 0;
   logic [QW+DW:0] sb[$];
   logic held = 1'b0;
   logic [QW+DW:0] held_val;

   function automatic void chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (rst) held = 1'b0;
      else begin
         if (held) chk("hold_stable", {rd_valid, rd_queue, rd_eof, rd_data}, {1'b1, held_val});
         if (rd_valid && rd_ready) begin
            if (sb.size() == 0) chk("unexpected_beat", {rd_queue, rd_eof, rd_data}, 0 - 1);
            else chk("rd_beat", {rd_queue, rd_eof, rd_data}, sb.pop_front());
         end
         held = rd_valid && !rd_ready;
         held_val = {rd_queue, rd_eof, rd_data};
         good_cnt += int'(status_good_frame);
         bad_cnt += int'(status_bad_frame);
         ovf_cnt += int'(status_overflow);
         nb_good_cnt += int'(nb_good);
         nb_bad_cnt += int'(nb_bad);
      end
   end

   task automatic send(input int q, input int n, input bit drop, input int base, input bit exp_rd);
      if (exp_rd)
         for (int i = 0; i < n; i++) sb.push_back({QW'(q), i == n - 1, DW'(base + i)});
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         wr_valid = 1'b1;
         wr_queue = (i == 0) ? QW'(q) : QW'(q + 1);
         wr_data  = DW'(base + i);
         wr_eof   = (i == n - 1);
         wr_drop  = drop && (i == n - 1);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_eof = 1'b0; wr_drop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_depth(input int q, input int val, input int budget, input string nm);
      int got = -1;
      for (int i = 0; i < budget && got != val; i++) begin
         @(negedge clk);
         got = int'(status_depth[q*(AW+1) +: AW+1]);
      end
      chk(nm, got, val);
   endtask

   task automatic drain(input int budget, input string nm);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      chk(nm, sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, b0, o0, ng0;
      idle(3);
      rst = 1'b0;
      chk("reset_rd", {rd_valid, rd_eof, rd_queue, rd_data}, 0);
      chk("reset_status", {status_depth, status_nonempty, status_overflow, status_bad_frame, status_good_frame}, 0);
      chk("wr_ready", wr_ready, 1);
      // 1: single frame to q2
      rd_ready = 1'b1;
      g0 = good_cnt;
      send(2, 3, 0, 'h200, 1);
      wait_depth(2, 3, 10, "t1_depth3");
      wait_depth(2, 0, 20, "t1_depth0");
      drain(20, "t1_drain");
      chk("t1_good_once", good_cnt - g0, 1);
      // 2: round-robin order
      rd_ready = 1'b0;
      send(0, 2, 0, 'h100, 1);
      send(1, 3, 0, 'h110, 1);
      send(3, 2, 0, 'h130, 1);
      idle(3);
      chk("t2_nonempty", status_nonempty, 4'b1011);
      rd_ready = 1'b1;
      idle(2);
      send(0, 2, 0, 'h140, 1);
      drain(60, "t2_drain");
      // 3: oversize frame then a DEPTH-beat frame
      o0 = ovf_cnt; g0 = good_cnt;
      send(1, 65, 0, 'h300, 0);
      idle(3);
      chk("t3_ovf", ovf_cnt - o0, 1);
      chk("t3_no_good", good_cnt - g0, 0);
      chk("t3_depth0", status_depth[1*(AW+1) +: AW+1], 0);
      send(1, 64, 0, 'h400, 1);
      idle(2);
      chk("t3_good", good_cnt - g0, 1);
      drain(200, "t3_drain");
      // 4: bad frame, dropped here, kept by the DROP_BAD_FRAME=0 instance
      b0 = bad_cnt; g0 = good_cnt; ng0 = nb_good_cnt;
      send(3, 4, 1, 'h600, 0);
      idle(3);
      chk("t4_bad", bad_cnt - b0, 1);
      chk("t4_no_good", good_cnt - g0, 0);
      chk("t4_depth", status_depth[3*(AW+1) +: AW+1], 0);
      chk("t4_nb_good", nb_good_cnt - ng0, 1);
      chk("t4_nb_bad", nb_bad_cnt, 0);
      idle(10);
      // 5: consumer stalls mid-frame
      rd_ready = 1'b0;
      send(2, 6, 0, 'h500, 1);
      idle(6);
      rd_ready = 1'b1; idle(1);
      rd_ready = 1'b0; idle(1);
      idle(1);
      rd_ready = 1'b1;
      drain(30, "t5_drain");
      // 6: reset during write and read
      send(0, 8, 0, 'h700, 1);
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_queue = 2'd1; wr_data = DW'('h7a0 + i);
         idle(1);
      end
      chk("t6_midread", rd_valid, 1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0; wr_valid = 1'b0;
      sb.delete();
      chk("t6_rd_zero", {rd_valid, rd_eof, rd_queue, rd_data}, 0);
      chk("t6_status_zero", {status_depth, status_nonempty, status_overflow, status_bad_frame, status_good_frame}, 0);
      send(0, 2, 0, 'h7c0, 1);
      drain(20, "t6_drain");
      idle(10);
      chk("final_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
